// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Bus bundle between the control unit / datapath and the
//               pc_sequencer. It carries the next-PC sources, the write
//               enables, the exception request and the PC/EPC/cause outputs.
//               The master modport is the control/datapath side and the
//               slave modport is the sequencer.
//   pc_src        2      next-PC select (0 alu_result, 1 alu_out,
//                        2 jump_target, 3 epc_q)
//   pc_write      1      unconditional PC write enable
//   pc_write_cond 1      branch PC write enable
//   branch_ne     1      0 = beq, 1 = bne
//   zero          1      ALU zero flag
//   alu_result    WIDTH  combinational ALU output
//   alu_out       WIDTH  registered ALUOut
//   jump_target   WIDTH  jump address
//   exc_req       1      exception request
//   exc_cause     1      0 invalid opcode, 1 overflow
//   pc_q          WIDTH  current PC
//   epc_q         WIDTH  exception PC
//   cause_q       2      last exception cause
//   exc_busy      1      high for the single exception cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       pc_src;
    logic             pc_write;
    logic             pc_write_cond;
    logic             branch_ne;
    logic             zero;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] jump_target;
    logic             exc_req;
    logic             exc_cause;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] epc_q;
    logic [1:0]       cause_q;
    logic             exc_busy;

    modport master (
        output pc_src, pc_write, pc_write_cond, branch_ne, zero,
               alu_result, alu_out, jump_target, exc_req, exc_cause,
        input  pc_q, epc_q, cause_q, exc_busy
    );

    modport slave (
        input  pc_src, pc_write, pc_write_cond, branch_ne, zero,
               alu_result, alu_out, jump_target, exc_req, exc_cause,
        output pc_q, epc_q, cause_q, exc_busy
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer for the multicycle MIPS datapath.
//               Holds PC and EPC, selects the next PC from ALU result,
//               ALUOut, jump target or EPC, handles beq/bne conditional
//               writes and runs a two-state exception FSM (RUN/EXC) that
//               saves PC into EPC and redirects fetch to a cause vector.
// Ports       : clk      - system clock, rising edge
//               reset_n  - synchronous active-low reset
//               bus      - pc_sequencer_if.slave (sources, enables,
//                          exception request, PC/EPC/cause/busy outputs)
// Options     : PC_ALIGN_CHECK_EN - when defined, a PC write whose target
//               has nonzero low two bits raises an address-error exception
//               (cause 2, vector VEC_ADE) instead of writing the PC.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter logic [WIDTH-1:0] VEC_OPCODE = 'h0000_00FD,
    parameter logic [WIDTH-1:0] VEC_OVF    = 'h0000_00FE,
    parameter logic [WIDTH-1:0] VEC_ADE    = 'h0000_00FF
) (
    input  logic          clk,
    input  logic          reset_n,
    pc_sequencer_if.slave bus
);

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_EXC = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [1:0]       cause_q, cause_d;
    logic [WIDTH-1:0] w_nxt;
    logic             w_we;

    // Next-PC source select
    always_comb begin
        w_nxt = bus.alu_result;
        case (bus.pc_src)
            2'd0:    w_nxt = bus.alu_result;
            2'd1:    w_nxt = bus.alu_out;
            2'd2:    w_nxt = bus.jump_target;
            default: w_nxt = epc_q;
        endcase
    end

    // Branch condition: beq writes on zero, bne writes on not-zero
    assign w_we = bus.pc_write | (bus.pc_write_cond & (bus.zero ^ bus.branch_ne));

`ifndef PC_ALIGN_CHECK_EN
    // Address-error vector has no use without the alignment check
    logic w_unused_vec_ade;
    assign w_unused_vec_ade = ^VEC_ADE;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        case (state_q)
            ST_RUN: begin
                // Exception request wins; any concurrent PC write is dropped
                if (bus.exc_req) begin
                    epc_d   = pc_q;
                    cause_d = {1'b0, bus.exc_cause};
                    pc_d    = bus.exc_cause ? VEC_OVF : VEC_OPCODE;
                    state_d = ST_EXC;
                end else if (w_we) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (w_nxt[1:0] != 2'b00) begin
                        epc_d   = pc_q;
                        cause_d = 2'd2;
                        pc_d    = VEC_ADE;
                        state_d = ST_EXC;
                    end else begin
                        pc_d = w_nxt;
                    end
`else
                    pc_d = w_nxt;
`endif
                end
            end
            // Single-cycle state: all requests are ignored here
            ST_EXC: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    assign bus.pc_q     = pc_q;
    assign bus.epc_q    = epc_q;
    assign bus.cause_q  = cause_q;
    assign bus.exc_busy = (state_q == ST_EXC);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. Directed scenarios
//               with literal expectations, then randomized stimulus; a
//               behavioural model tracks PC/EPC/cause/busy and a compare
//               process checks the DUT against it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
    localparam int          WIDTH = 32;
    localparam logic [31:0] V_OPC = 32'h0000_00FD;
    localparam logic [31:0] V_OVF = 32'h0000_00FE;
    localparam logic [31:0] V_ADE = 32'h0000_00FF;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    pc_sequencer_if #(.WIDTH(WIDTH)) bus ();

    pc_sequencer #(
        .WIDTH(WIDTH), .RESET_PC(32'h0), .VEC_OPCODE(V_OPC),
        .VEC_OVF(V_OVF), .VEC_ADE(V_ADE)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural registers plus a "just took an
    // exception" flag that blocks the following cycle.
    logic [31:0] m_pc, m_epc;
    logic [1:0]  m_cause;
    logic        m_busy;
    bit          align_chk;

    initial begin
`ifdef PC_ALIGN_CHECK_EN
        align_chk = 1'b1;
`else
        align_chk = 1'b0;
`endif
    end

    always @(posedge clk) begin
        logic [31:0] src [4];
        logic [31:0] target;
        bit          take;
        src[0] = bus.alu_result;
        src[1] = bus.alu_out;
        src[2] = bus.jump_target;
        src[3] = m_epc;
        target = src[bus.pc_src];
        take   = bus.pc_write || (bus.pc_write_cond && (bus.zero != bus.branch_ne));
        if (!reset_n) begin
            m_pc <= 32'h0; m_epc <= 32'h0; m_cause <= 2'd0; m_busy <= 1'b0;
        end else if (m_busy) begin
            m_busy <= 1'b0;
        end else if (bus.exc_req) begin
            m_epc   <= m_pc;
            m_cause <= bus.exc_cause ? 2'd1 : 2'd0;
            m_pc    <= bus.exc_cause ? V_OVF : V_OPC;
            m_busy  <= 1'b1;
        end else if (take) begin
            if (align_chk && (target % 4 != 0)) begin
                m_epc <= m_pc; m_cause <= 2'd2; m_pc <= V_ADE; m_busy <= 1'b1;
            end else begin
                m_pc <= target;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            total = total + 1;
            if (bus.pc_q !== m_pc || bus.epc_q !== m_epc ||
                bus.cause_q !== m_cause || bus.exc_busy !== m_busy) begin
                bad = bad + 1;
                $display("FAIL model-cmp t=%0t dut pc=%h epc=%h cause=%0d busy=%b expected pc=%h epc=%h cause=%0d busy=%b",
                         $time, bus.pc_q, bus.epc_q, bus.cause_q, bus.exc_busy,
                         m_pc, m_epc, m_cause, m_busy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.pc_src = 2'd0; bus.pc_write = 1'b0; bus.pc_write_cond = 1'b0;
        bus.branch_ne = 1'b0; bus.zero = 1'b0; bus.exc_req = 1'b0; bus.exc_cause = 1'b0;
        bus.alu_result = '0; bus.alu_out = '0; bus.jump_target = '0;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(3) != 0) v[1:0] = 2'b00;
        return v;
    endfunction

    initial begin
        idle();
        // Reset while a write is requested
        reset_n = 1'b0; bus.pc_write = 1'b1; bus.alu_result = 32'h40;
        tick(); tick();
        chk_en = 1'b1;
        chk("reset pc", bus.pc_q, 32'h0);
        chk("reset epc", bus.epc_q, 32'h0);
        chk("reset cause", {30'b0, bus.cause_q}, 32'h0);
        chk("reset busy", {31'b0, bus.exc_busy}, 32'h0);

        // Sequential fetch
        reset_n = 1'b1; bus.alu_result = 32'h4;
        tick(); chk("fetch 4", bus.pc_q, 32'h4);
        bus.alu_result = 32'h8;
        tick(); chk("fetch 8", bus.pc_q, 32'h8);

        // Branches
        bus.pc_write = 1'b0; bus.pc_write_cond = 1'b1; bus.pc_src = 2'd1;
        bus.alu_out = 32'h100; bus.zero = 1'b1; bus.branch_ne = 1'b0;
        tick(); chk("beq taken", bus.pc_q, 32'h100);
        bus.branch_ne = 1'b1; bus.alu_out = 32'h200;
        tick(); chk("bne not taken", bus.pc_q, 32'h100);

        // Exception and return
        bus.pc_write_cond = 1'b0; bus.pc_write = 1'b1; bus.pc_src = 2'd0;
        bus.alu_result = 32'h20;
        tick(); chk("pc to 0x20", bus.pc_q, 32'h20);
        bus.exc_req = 1'b1; bus.exc_cause = 1'b1; bus.alu_result = 32'h44;
        tick();
        chk("exc epc", bus.epc_q, 32'h20);
        chk("exc pc", bus.pc_q, V_OVF);
        chk("exc cause", {30'b0, bus.cause_q}, 32'h1);
        chk("exc busy", {31'b0, bus.exc_busy}, 32'h1);
        bus.exc_req = 1'b0;
        tick();
        chk("exc write ignored", bus.pc_q, V_OVF);
        chk("busy drops", {31'b0, bus.exc_busy}, 32'h0);
        bus.pc_src = 2'd3;
        tick();
        chk("eret pc", bus.pc_q, 32'h20);
        chk("eret epc", bus.epc_q, 32'h20);

        // Reset mid-exception
        bus.pc_write = 1'b0; bus.exc_req = 1'b1; bus.exc_cause = 1'b0;
        tick();
        chk("opcode vec", bus.pc_q, V_OPC);
        chk("opcode cause", {30'b0, bus.cause_q}, 32'h0);
        bus.exc_req = 1'b0; reset_n = 1'b0;
        tick();
        chk("midexc reset pc", bus.pc_q, 32'h0);
        chk("midexc reset epc", bus.epc_q, 32'h0);
        chk("midexc reset busy", {31'b0, bus.exc_busy}, 32'h0);
        reset_n = 1'b1;

        // Alignment
        bus.pc_write = 1'b1; bus.pc_src = 2'd0; bus.alu_result = 32'h10;
        tick(); chk("pc to 0x10", bus.pc_q, 32'h10);
        bus.pc_src = 2'd2; bus.jump_target = 32'h102;
        tick();
`ifdef PC_ALIGN_CHECK_EN
        chk("ade pc", bus.pc_q, V_ADE);
        chk("ade epc", bus.epc_q, 32'h10);
        chk("ade cause", {30'b0, bus.cause_q}, 32'h2);
`else
        chk("unaligned jump", bus.pc_q, 32'h102);
`endif
        idle();
        tick();

        // Randomized phase, checked by the model compare process
        for (int i = 0; i < 3000; i++) begin
            reset_n           = ($urandom_range(60) != 0);
            bus.pc_src        = 2'($urandom_range(3));
            bus.pc_write      = ($urandom_range(2) == 0);
            bus.pc_write_cond = ($urandom_range(2) == 0);
            bus.branch_ne     = 1'($urandom);
            bus.zero          = 1'($urandom);
            bus.exc_req       = ($urandom_range(7) == 0);
            bus.exc_cause     = 1'($urandom);
            bus.alu_result    = rnd_addr();
            bus.alu_out       = rnd_addr();
            bus.jump_target   = rnd_addr();
            tick();
        end
        idle();
        tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
